// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration interface: requests and mux output in, grant/select/registered bus out.
// Ports: req[4], bus_data_in[DATA_W] (to arbiter); gnt[4], sel[2], bus_valid, bus_data_q[DATA_W], done (from arbiter).
// master = arbiter side, slave = requester/bus-fabric side.
interface bus_arbiter_rr_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] bus_data_in;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data_q;
  logic              done;

  modport master (
    input  req, bus_data_in,
    output gnt, sel, bus_valid, bus_data_q, done
  );

  modport slave (
    output req, bus_data_in,
    input  gnt, sel, bus_valid, bus_data_q, done
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter for the 4-source internal CPU bus; registers the muxed bus value.
// Ports: clk, rst_n (async active-low), bus (master modport: req/bus_data_in in; gnt/sel/bus_valid/bus_data_q/done out).
// Latency: grant one edge after req sampled in IDLE; tenure bounded by HOLD_MAX, then 2-cycle gap (RELEASE + IDLE).
module bus_arbiter_rr #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_rr_if.master  bus
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [CW-1:0]     hold_cnt;
  logic [3:0]        gnt_q;
  logic [1:0]        sel_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;

  logic [1:0]        win;
  logic [1:0]        cand;
  logic              found;

  // Cyclic priority scan starting at ptr; first requester found wins.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (|bus.req) begin
            state    <= OWN;
            gnt_q    <= 4'b0001 << win;
            sel_q    <= win;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end

        OWN: begin
          data_q <= bus.bus_data_in;
          // Owner drop and timeout landing on the same edge still yield one exit.
          if (!bus.req[sel_q] || (hold_cnt == CW'(HOLD_MAX - 1))) begin
            state    <= RELEASE;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b1;
            ptr      <= sel_q + 2'd1;
            // Cleared rather than incremented so the counter never passes HOLD_MAX-1.
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end

        RELEASE: begin
          // Bus turnaround cycle: sel and data_q hold their values.
          state   <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.bus_valid  = valid_q;
  assign bus.bus_data_q = data_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus a random soak.
// A reference model pushes each expected tenure (owner, length, last data) into a queue;
// the output monitor pops and compares on every done pulse, and checks bus invariants each cycle.
module tb_bus_arbiter_rr;

  localparam int DATA_W   = 8;
  localparam int HOLD_MAX = 4;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] bus_data_in;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data_q;
  logic              done;

  bus_arbiter_rr_if #(.DATA_W(DATA_W)) bif ();

  assign bif.req         = req;
  assign bif.bus_data_in = bus_data_in;
  assign gnt             = bif.gnt;
  assign sel             = bif.sel;
  assign bus_valid       = bif.bus_valid;
  assign bus_data_q      = bif.bus_data_q;
  assign done            = bif.done;

  bus_arbiter_rr #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int owner;
    int len;
    int data;
  } ten_t;

  ten_t sb_q[$];
  int   hist_owner[$];
  int   hist_len[$];
  int   hist_gap[$];

  // Reference model: tenure-level view, pushes one record per completed tenure.
  int m_state = 0;
  int m_ptr   = 0;
  int m_owner = 0;
  int m_len   = 0;
  int m_data  = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      m_len   = 0;
      sb_q.delete();
    end else begin
      case (m_state)
        0: if (req != 4'b0000) begin
          for (int k = 3; k >= 0; k--)
            if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
          m_len   = 0;
          m_state = 1;
        end
        1: begin
          m_len++;
          m_data = int'(bus_data_in);
          if (!req[m_owner] || m_len == HOLD_MAX) begin
            sb_q.push_back('{m_owner, m_len, m_data});
            m_ptr   = (m_owner + 1) % 4;
            m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  // Output monitor, sampling mid-cycle.
  int              cur_len = 0;
  int              cur_owner = 0;
  int              gap = 0;
  int              n_done = 0;
  bit              had_ten = 0;
  logic            prev_valid = 1'b0;
  logic [1:0]      prev_sel = '0;
  logic [DATA_W-1:0] prev_dq = '0;
  logic [DATA_W-1:0] prev_din = '0;

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      cur_len    = 0;
      gap        = 0;
      had_ten    = 0;
      prev_valid = 1'b0;
      prev_sel   = '0;
      prev_dq    = '0;
      prev_din   = bus_data_in;
    end else begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_vs_gnt", 32'(bus_valid), 32'(|gnt));
      if (sel != prev_sel) chk("sel_change_on_grant", 32'(bus_valid && !prev_valid), 32'd1);
      if (bus_data_q != prev_dq) chk("dq_change_in_own", 32'(prev_valid), 32'd1);
      if (prev_valid) chk("dq_track", 32'(bus_data_q), 32'(prev_din));
      if (bus_valid) begin
        chk("sel_matches_gnt", 32'(gnt), 32'(4'b0001 << sel));
        if (!prev_valid) begin
          if (had_ten) hist_gap.push_back(gap);
          gap       = 0;
          cur_owner = int'(sel);
          cur_len   = 0;
        end
        cur_len++;
        chk("hold_limit", 32'(cur_len <= HOLD_MAX), 32'd1);
      end else begin
        gap++;
      end
      if (done) begin
        n_done++;
        chk("done_after_own", 32'(prev_valid), 32'd1);
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          ten_t e;
          e = sb_q.pop_front();
          chk("sb_owner", 32'(cur_owner), 32'(e.owner));
          chk("sb_len", 32'(cur_len), 32'(e.len));
          chk("sb_data", 32'(bus_data_q), 32'(e.data));
        end
        hist_owner.push_back(cur_owner);
        hist_len.push_back(cur_len);
        had_ten = 1;
        gap     = 1;
      end
      prev_valid = bus_valid;
      prev_sel   = sel;
      prev_dq    = bus_data_q;
      prev_din   = bus_data_in;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      bus_data_in = DATA_W'($urandom);
    end
  endtask

  task automatic clear_hist();
    hist_owner.delete();
    hist_len.delete();
    hist_gap.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_hist(input int n, input int budget);
    int b;
    b = 0;
    while (hist_owner.size() < n && b < budget) begin
      step(1);
      b++;
    end
    chk("wait_tenures", 32'(hist_owner.size() >= n), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = 4'b0000;
    bus_data_in = '0;
    step(3);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_dq", 32'(bus_data_q), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single requester, two OWN cycles, then ptr moves to 1.
    clear_hist();
    req = 4'b0001;
    step(1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_sel", 32'(sel), 32'd0);
    chk("t1_valid", 32'(bus_valid), 32'd1);
    step(1);
    req = 4'b0000;
    step(1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_off", 32'(bus_valid), 32'd0);
    step(1);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_tenures", 32'(hist_owner.size()), 32'd1);
    if (hist_len.size() > 0) chk("t1_len", 32'(hist_len[0]), 32'd2);
    req = 4'b0011;
    step(1);
    chk("t1_ptr_next", 32'(gnt), 32'h2);
    req = 4'b0000;
    step(4);

    // All requesting: 0,1,2,3,0 at HOLD_MAX each with 2-cycle gaps.
    do_reset();
    clear_hist();
    req = 4'b1111;
    wait_hist(5, 200);
    req = 4'b0000;
    step(3);
    for (int i = 0; i < 5; i++) begin
      if (i < hist_owner.size()) begin
        chk("t2_owner", 32'(hist_owner[i]), 32'(i % 4));
        chk("t2_len", 32'(hist_len[i]), 32'(HOLD_MAX));
      end
    end
    chk("t2_gap_count", 32'(hist_gap.size()), 32'd4);
    foreach (hist_gap[i]) chk("t2_gap", 32'(hist_gap[i]), 32'd2);

    // Owner 3: timeout and request drop on the same edge.
    do_reset();
    clear_hist();
    req = 4'b1000;
    step(4);
    req = 4'b0000;
    step(3);
    chk("t3_tenures", 32'(hist_owner.size()), 32'd1);
    if (hist_owner.size() > 0) begin
      chk("t3_owner", 32'(hist_owner[0]), 32'd3);
      chk("t3_len", 32'(hist_len[0]), 32'(HOLD_MAX));
    end
    req = 4'b1001;
    step(1);
    chk("t3_wrap_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step(4);

    // No preemption: req[0] raised while source 1 owns the bus.
    clear_hist();
    req = 4'b0010;
    step(1);
    chk("t4_gnt1", 32'(gnt), 32'h2);
    step(1);
    req = 4'b0011;
    step(1);
    chk("t4_hold_a", 32'(gnt), 32'h2);
    step(1);
    chk("t4_hold_b", 32'(gnt), 32'h2);
    wait_hist(2, 50);
    req = 4'b0000;
    step(3);
    if (hist_owner.size() >= 2) begin
      chk("t4_first", 32'(hist_owner[0]), 32'd1);
      chk("t4_first_len", 32'(hist_len[0]), 32'(HOLD_MAX));
      chk("t4_second", 32'(hist_owner[1]), 32'd0);
    end

    // Asynchronous reset in the middle of an OWN tenure.
    clear_hist();
    req = 4'b0100;
    step(1);
    chk("t5_gnt", 32'(gnt), 32'h4);
    chk("t5_sel", 32'(sel), 32'd2);
    step(2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_sel", 32'(sel), 32'd0);
    chk("t5_rst_valid", 32'(bus_valid), 32'd0);
    chk("t5_rst_dq", 32'(bus_data_q), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t5_regnt", 32'(gnt), 32'h4);
    chk("t5_resel", 32'(sel), 32'd2);
    req = 4'b0000;
    step(6);

    // Random soak; monitor checks invariants and the scoreboard every cycle.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      step(1);
    end
    req = 4'b0000;
    step(10);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    chk("soak_done_seen", 32'(n_done > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
